// File: rtl/draw_sequencer_pkg.sv
// Shared definitions for the frame draw sequencer: screen geometry, colour key,
// coordinate widths and the frame state encoding.
package draw_sequencer_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam logic [7:0]  TRANSPARENT = 8'hE3;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int SPR_W = 6;
  localparam int COL_W = 8;
  localparam int SX_W  = X_W + 1;
  localparam int SY_W  = Y_W + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BG_RUN  = 3'd1,
    BG_REL  = 3'd2,
    SPR_RUN = 3'd3,
    SPR_REL = 3'd4,
    FINISH  = 3'd5
  } state_t;

endpackage

// File: rtl/draw_sequencer_pixel_merge.sv
// Merges background and sprite pixel streams into one registered plot port,
// with sprite offset translation, off-screen clipping and colour keying.
module draw_sequencer_pixel_merge
  import draw_sequencer_pkg::*;
#(
  parameter int unsigned      SCREEN_W    = draw_sequencer_pkg::SCREEN_W,
  parameter int unsigned      SCREEN_H    = draw_sequencer_pkg::SCREEN_H,
  parameter logic [COL_W-1:0] TRANSPARENT = draw_sequencer_pkg::TRANSPARENT
) (
  input  logic             clk,
  input  logic             reset,
  input  state_t           state,
  input  logic [X_W-1:0]   latch_x,
  input  logic [Y_W-1:0]   latch_y,
  input  logic [X_W-1:0]   bg_x,
  input  logic [Y_W-1:0]   bg_y,
  input  logic [COL_W-1:0] bg_colour,
  input  logic             bg_write_en,
  input  logic [SPR_W-1:0] spr_x,
  input  logic [SPR_W-1:0] spr_y,
  input  logic [COL_W-1:0] spr_colour,
  input  logic             spr_write_en,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [COL_W-1:0] colour,
  output logic             plot
);

  logic [SX_W-1:0] sx;
  logic [SY_W-1:0] sy;
  logic            bg_take;
  logic            spr_take;

  // Sums are one bit wider than the screen coordinate so overflow clips, not wraps.
  always_comb begin
    sx       = {1'b0, latch_x} + SX_W'(spr_x);
    sy       = {1'b0, latch_y} + SY_W'(spr_y);
    bg_take  = (state == BG_RUN) && bg_write_en;
    spr_take = (state == SPR_RUN) && spr_write_en
               && (sx < SX_W'(SCREEN_W)) && (sy < SY_W'(SCREEN_H))
               && (spr_colour != TRANSPARENT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      plot <= bg_take | spr_take;
      if (bg_take) begin
        x      <= bg_x;
        y      <= bg_y;
        colour <= bg_colour;
      end else if (spr_take) begin
        x      <= sx[X_W-1:0];
        y      <= sy[Y_W-1:0];
        colour <= spr_colour;
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Frame controller: runs the background stage then the sprite stage on each
// frame request, with a one-deep pending request and a latched sprite position.
module draw_sequencer
  import draw_sequencer_pkg::*;
#(
  parameter int unsigned      SCREEN_W    = draw_sequencer_pkg::SCREEN_W,
  parameter int unsigned      SCREEN_H    = draw_sequencer_pkg::SCREEN_H,
  parameter logic [COL_W-1:0] TRANSPARENT = draw_sequencer_pkg::TRANSPARENT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frameReq,
  input  logic [X_W-1:0]   spriteX,
  input  logic [Y_W-1:0]   spriteY,
  output logic             bgStart,
  input  logic [X_W-1:0]   bgX,
  input  logic [Y_W-1:0]   bgY,
  input  logic [COL_W-1:0] bgColour,
  input  logic             bgWriteEn,
  input  logic             bgDone,
  output logic             sprStart,
  input  logic [SPR_W-1:0] sprX,
  input  logic [SPR_W-1:0] sprY,
  input  logic [COL_W-1:0] sprColour,
  input  logic             sprWriteEn,
  input  logic             sprDone,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [COL_W-1:0] colour,
  output logic             plot,
  output logic             busy,
  output logic             frameDone
);

  state_t         state;
  logic           pending;
  logic [X_W-1:0] latch_x;
  logic [Y_W-1:0] latch_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= 1'b0;
      latch_x   <= '0;
      latch_y   <= '0;
      bgStart   <= 1'b0;
      sprStart  <= 1'b0;
      busy      <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      // A frame start below overrides this and clears pending.
      if (frameReq && busy) pending <= 1'b1;
      case (state)
        IDLE, FINISH: begin
          if (frameReq || pending) begin
            state   <= BG_RUN;
            bgStart <= 1'b1;
            busy    <= 1'b1;
            pending <= 1'b0;
            latch_x <= spriteX;
            latch_y <= spriteY;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        BG_RUN: begin
          if (bgDone) begin
            state   <= BG_REL;
            bgStart <= 1'b0;
          end
        end
        BG_REL: begin
          if (!bgDone) begin
            state    <= SPR_RUN;
            sprStart <= 1'b1;
          end
        end
        SPR_RUN: begin
          if (sprDone) begin
            state    <= SPR_REL;
            sprStart <= 1'b0;
          end
        end
        SPR_REL: begin
          if (!sprDone) begin
            state     <= FINISH;
            frameDone <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bgStart  <= 1'b0;
          sprStart <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  draw_sequencer_pixel_merge #(
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H),
    .TRANSPARENT(TRANSPARENT)
  ) u_pixel_merge (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .latch_x     (latch_x),
    .latch_y     (latch_y),
    .bg_x        (bgX),
    .bg_y        (bgY),
    .bg_colour   (bgColour),
    .bg_write_en (bgWriteEn),
    .spr_x       (sprX),
    .spr_y       (sprY),
    .spr_colour  (sprColour),
    .spr_write_en(sprWriteEn),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot)
  );

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: stub draw stages, a frame-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_draw_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frameReq = 1'b0;
  logic [7:0] spriteX = 8'd0;
  logic [6:0] spriteY = 7'd0;
  logic       bgStart, sprStart;
  logic [7:0] bgX, bgColour, sprColour;
  logic [6:0] bgY;
  logic       bgWriteEn, bgDone, sprWriteEn, sprDone;
  logic [5:0] sprX, sprY;
  logic [7:0] x, colour;
  logic [6:0] y;
  logic       plot, busy, frameDone;

  always #5 clk = ~clk;

  draw_sequencer u_dut (
    .clk       (clk),
    .reset     (reset),
    .frameReq  (frameReq),
    .spriteX   (spriteX),
    .spriteY   (spriteY),
    .bgStart   (bgStart),
    .bgX       (bgX),
    .bgY       (bgY),
    .bgColour  (bgColour),
    .bgWriteEn (bgWriteEn),
    .bgDone    (bgDone),
    .sprStart  (sprStart),
    .sprX      (sprX),
    .sprY      (sprY),
    .sprColour (sprColour),
    .sprWriteEn(sprWriteEn),
    .sprDone   (sprDone),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .frameDone (frameDone)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stub draw stages ----------------
  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [7:0] c;} px_t;
  px_t bg_tab[16];
  px_t spr_tab[16];
  int  bg_n = 0, spr_n = 0, pre_wait = 0, noise = 0;
  bit  rand_mode = 0;

  initial begin
    int idx, cnt, wt;
    bit act;
    act = 0; idx = 0; cnt = 0; wt = 0;
    bgWriteEn = 0; bgDone = 0; bgX = 0; bgY = 0; bgColour = 0;
    forever begin
      @(negedge clk);
      if (reset || !bgStart) begin
        act = 0; bgDone = 0; bgWriteEn = 0;
        if (noise == 2 || (noise == 1 && $urandom_range(0, 1) == 1)) begin
          bgWriteEn = 1; bgX = 8'($urandom_range(0, 159)); bgY = 7'($urandom_range(0, 119));
          bgColour = 8'($urandom);
        end
      end else begin
        if (!act) begin
          act = 1; idx = 0; wt = pre_wait;
          cnt = rand_mode ? $urandom_range(0, 12) : bg_n;
        end
        bgWriteEn = 0;
        if (wt > 0) wt--;
        else if (idx < cnt) begin
          if (!rand_mode || $urandom_range(0, 3) != 0) begin
            bgWriteEn = 1;
            if (rand_mode) begin
              bgX = 8'($urandom); bgY = 7'($urandom); bgColour = 8'($urandom);
            end else begin
              bgX = bg_tab[idx].x; bgY = bg_tab[idx].y; bgColour = bg_tab[idx].c;
            end
            idx++;
          end
        end else bgDone = 1;
      end
    end
  end

  initial begin
    int idx, cnt, wt;
    bit act;
    act = 0; idx = 0; cnt = 0; wt = 0;
    sprWriteEn = 0; sprDone = 0; sprX = 0; sprY = 0; sprColour = 0;
    forever begin
      @(negedge clk);
      if (reset || !sprStart) begin
        act = 0; sprDone = 0; sprWriteEn = 0;
        if (noise == 2 || (noise == 1 && $urandom_range(0, 1) == 1)) begin
          sprWriteEn = 1; sprX = 6'($urandom_range(0, 39)); sprY = 6'($urandom_range(0, 39));
          sprColour = 8'h55;
        end
      end else begin
        if (!act) begin
          act = 1; idx = 0; wt = pre_wait;
          cnt = rand_mode ? $urandom_range(0, 20) : spr_n;
        end
        sprWriteEn = 0;
        if (wt > 0) wt--;
        else if (idx < cnt) begin
          if (!rand_mode || $urandom_range(0, 3) != 0) begin
            sprWriteEn = 1;
            if (rand_mode) begin
              sprX = 6'($urandom_range(0, 39)); sprY = 6'($urandom_range(0, 39));
              sprColour = ($urandom_range(0, 3) == 0) ? 8'hE3 : 8'($urandom);
            end else begin
              sprX = spr_tab[idx].x[5:0]; sprY = spr_tab[idx].y[5:0];
              sprColour = spr_tab[idx].c;
            end
            idx++;
          end
        end else sprDone = 1;
      end
    end
  end

  // ---------------- reference model ----------------
  localparam int M_OFF = 0, M_BG = 1, M_BG_WAIT = 2, M_SPR = 3, M_SPR_WAIT = 4, M_END = 5;
  int         m_stage = M_OFF;
  bit         m_queued = 0, m_ok = 0, m_rst = 0;
  logic [7:0] m_lx = 0;
  logic [6:0] m_ly = 0;
  logic       e_plot = 0;
  logic [7:0] e_x = 0, e_col = 0;
  logic [6:0] e_y = 0;

  task automatic new_frame();
    m_stage = M_BG; m_queued = 0; m_lx = spriteX; m_ly = spriteY;
  endtask

  initial begin
    int sx, sy;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_stage = M_OFF; m_queued = 0; m_lx = 0; m_ly = 0;
        e_plot = 0; e_x = 0; e_y = 0; e_col = 0; m_ok = 1; m_rst = 1;
      end else begin
        m_rst = 0;
        e_plot = 0;
        if (m_stage == M_BG && bgWriteEn) begin
          e_plot = 1; e_x = bgX; e_y = bgY; e_col = bgColour;
        end
        if (m_stage == M_SPR && sprWriteEn) begin
          sx = int'(m_lx) + int'(sprX);
          sy = int'(m_ly) + int'(sprY);
          if (sx < 160 && sy < 120 && sprColour != 8'hE3) begin
            e_plot = 1; e_x = sx[7:0]; e_y = sy[6:0]; e_col = sprColour;
          end
        end
        if (m_stage != M_OFF && frameReq) m_queued = 1;
        case (m_stage)
          M_OFF:      if (frameReq) new_frame();
          M_BG:       if (bgDone) m_stage = M_BG_WAIT;
          M_BG_WAIT:  if (!bgDone) m_stage = M_SPR;
          M_SPR:      if (sprDone) m_stage = M_SPR_WAIT;
          M_SPR_WAIT: if (!sprDone) m_stage = M_END;
          default:    if (m_queued) new_frame(); else m_stage = M_OFF;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        check("bgStart", bgStart, m_stage == M_BG);
        check("sprStart", sprStart, m_stage == M_SPR);
        check("busy", busy, m_stage != M_OFF);
        check("frameDone", frameDone, m_stage == M_END);
        check("plot", plot, e_plot);
        if (e_plot || m_rst) begin
          check("x", x, e_x);
          check("y", y, e_y);
          check("colour", colour, e_col);
        end
      end
    end
  end

  // ---------------- event log ----------------
  logic [7:0] lx[$], lc[$];
  logic [6:0] ly[$];
  int fd_q[$], bs_q[$], ss_q[$];
  int m_plots = 0, bg_hi = 0, last_bg = 0;
  logic bg_prev = 0, spr_prev = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (plot) begin lx.push_back(x); ly.push_back(y); lc.push_back(colour); end
      if (m_ok && e_plot) m_plots++;
      if (frameDone) fd_q.push_back(cyc);
      if (bgStart && !bg_prev) bs_q.push_back(cyc);
      if (sprStart && !spr_prev) ss_q.push_back(cyc);
      if (bgStart) begin bg_hi++; last_bg = cyc; end
      bg_prev = bgStart; spr_prev = sprStart;
    end
  end

  task automatic clear_logs();
    lx.delete(); ly.delete(); lc.delete();
    fd_q.delete(); bs_q.delete(); ss_q.delete();
    m_plots = 0; bg_hi = 0; last_bg = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_req();
    frameReq = 1; tick(); frameReq = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin tick(); n++; end
    check("idle_reached", busy, 0);
  endtask

  task automatic run_frame();
    clear_logs(); pulse_req(); wait_idle(400); repeat (2) tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_bgStart"}, bgStart, 0);
    check({tag, "_sprStart"}, sprStart, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_colour"}, colour, 0);
    check({tag, "_plot"}, plot, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frameDone"}, frameDone, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick();
    check_zero_outputs("reset");
    reset = 0;
    tick();

    // Basic frame: 5 background then 5 sprite pixels.
    for (int i = 0; i < 5; i++) begin
      bg_tab[i]  = '{x: 8'(10 + i), y: 7'(20 + i), c: 8'(i + 1)};
      spr_tab[i] = '{x: 8'(i), y: 7'(i), c: 8'(8'h10 + i)};
    end
    bg_n = 5; spr_n = 5;
    clear_logs();
    pulse_req();
    check("req_busy", busy, 1);
    check("req_bgStart", bgStart, 1);
    wait_idle(400);
    repeat (2) tick();
    check("basic_plots", lx.size(), 10);
    check("basic_model_plots", m_plots, 10);
    check("basic_frameDone", fd_q.size(), 1);
    check("basic_bg_long", bg_hi >= 5, 1);
    check("basic_spr_after_bg", ss_q.size() == 1 && ss_q[0] > last_bg, 1);
    check("basic_busy_end", busy, 0);

    // Clipping at the screen edge.
    spriteX = 8'd150; spriteY = 7'd100;
    bg_n = 0; spr_n = 2;
    spr_tab[0] = '{x: 8'd12, y: 7'd25, c: 8'h11};
    spr_tab[1] = '{x: 8'd5, y: 7'd10, c: 8'h22};
    run_frame();
    check("clip_count", lx.size(), 1);
    check("clip_model_count", m_plots, 1);
    check("clip_x", lx.size() > 0 ? 32'(lx[0]) : 32'hdead, 155);
    check("clip_y", ly.size() > 0 ? 32'(ly[0]) : 32'hdead, 110);
    check("clip_colour", lc.size() > 0 ? 32'(lc[0]) : 32'hdead, 8'h22);

    // Transparent colour key.
    spriteX = 8'd10; spriteY = 7'd10;
    spr_tab[0] = '{x: 8'd1, y: 7'd1, c: 8'hE3};
    spr_tab[1] = '{x: 8'd2, y: 7'd2, c: 8'hE2};
    run_frame();
    check("key_count", lx.size(), 1);
    check("key_model_count", m_plots, 1);
    check("key_x", lx.size() > 0 ? 32'(lx[0]) : 32'hdead, 12);
    check("key_colour", lc.size() > 0 ? 32'(lc[0]) : 32'hdead, 8'hE2);

    // Inactive-layer writes are ignored.
    spriteX = 8'd0; spriteY = 7'd0;
    bg_n = 0; spr_n = 0; pre_wait = 6; noise = 2;
    run_frame();
    noise = 0;
    check("inactive_plots", lx.size(), 0);

    // Two requests during BG_RUN give exactly one extra frame, back to back.
    bg_n = 3; spr_n = 3; pre_wait = 2;
    clear_logs();
    pulse_req();
    tick();
    pulse_req();
    pulse_req();
    wait_idle(800);
    repeat (10) tick();
    check("pend_frames", fd_q.size(), 2);
    check("pend_starts", bs_q.size(), 2);
    check("pend_restart_cycle",
          (bs_q.size() > 1 && fd_q.size() > 0) ? bs_q[1] - fd_q[0] : 32'hdead, 1);
    check("pend_idle", busy, 0);

    // Reset during sprite drawing aborts the frame.
    spr_n = 10;
    pulse_req();
    n = 0;
    while (sprStart !== 1'b1 && n < 100) begin tick(); n++; end
    check("abort_spr_reached", sprStart, 1);
    repeat (2) tick();
    reset = 1;
    tick();
    check_zero_outputs("abort");
    reset = 0;
    tick();
    pulse_req();
    check("abort_restart_bg", bgStart, 1);
    check("abort_restart_spr", sprStart, 0);
    wait_idle(400);

    // Randomized traffic checked against the model every cycle.
    rand_mode = 1; noise = 1;
    for (int i = 0; i < 5000; i++) begin
      frameReq = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) begin
        spriteX = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(100, 159)) : 8'($urandom);
        spriteY = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(70, 119)) : 7'($urandom);
      end
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 99) == 0) pre_wait = $urandom_range(0, 3);
      tick();
    end
    frameReq = 0; reset = 0;
    wait_idle(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Frame-level controller that sits directly upstream and downstream of the 160x120 background draw stage and the 40x40 sprite draw stage. On each frame request it runs the background draw, then the sprite draw, using their level-held start / done handshake. It merges both pixel streams into a single registered plot port for the VGA adapter. Sprite pixels get screen-offset translation, off-screen clipping and transparent-colour keying.

## Interface
Parameters:
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- TRANSPARENT, 8'hE3, sprite colour key; matching pixels are not plotted

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frameReq  in  1  single-cycle request to redraw one frame
- spriteX  in  8  sprite top-left x; sampled at frame start
- spriteY  in  7  sprite top-left y; sampled at frame start
- bgStart  out  1  level start to background stage
- bgX  in  8  background pixel x
- bgY  in  7  background pixel y
- bgColour  in  8  background pixel colour
- bgWriteEn  in  1  background pixel valid
- bgDone  in  1  background stage finished
- sprStart  out  1  level start to sprite stage
- sprX  in  6  sprite-local x, 0..39
- sprY  in  6  sprite-local y, 0..39
- sprColour  in  8  sprite pixel colour
- sprWriteEn  in  1  sprite pixel valid
- sprDone  in  1  sprite stage finished
- x  out  8  VGA plot x
- y  out  7  VGA plot y
- colour  out  8  VGA plot colour
- plot  out  1  VGA write strobe
- busy  out  1  frame in progress
- frameDone  out  1  single-cycle pulse when the frame completes

## Operation
The FSM has six states:
- IDLE
  - frameReq or pending -> BG_RUN
  - On entry to BG_RUN, latch spriteX/spriteY and clear pending.
- BG_RUN
  - bgStart=1.
  - bgDone=1 -> BG_REL.
- BG_REL
  - bgStart=0.
  - Wait until bgDone=0, then -> SPR_RUN.
  - The stage leaves its DONE state only when start drops.
- SPR_RUN
  - sprStart=1.
  - sprDone=1 -> SPR_REL.
- SPR_REL
  - sprStart=0.
  - sprDone=0 -> FINISH.
- FINISH
  - frameDone=1 for one cycle.
  - pending -> BG_RUN (re-latching the position); else -> IDLE.

Rules:
- busy=1 in every state except IDLE.
- frameReq while busy sets a one-deep pending flag. Further requests while pending=1 are dropped.
- Pixel merge accepts only the active layer's writeEn:
  - BG_RUN accepts bgWriteEn.
  - SPR_RUN accepts sprWriteEn.
  - A writeEn from the inactive layer is ignored.
- Background pixel: x=bgX, y=bgY, colour=bgColour, plotted unconditionally.
- Sprite pixel:
  - sx = {1'b0,latchX} + sprX (9 bits); sy = {1'b0,latchY} + sprY (8 bits).
  - Plot only if sx < SCREEN_W, sy < SCREEN_H and sprColour != TRANSPARENT.
  - Outputs x=sx[7:0], y=sy[6:0]. No wrap-around: out-of-range pixels are dropped.
- Changing spriteX/spriteY mid-frame has no effect until the next frame start.

## Timing
- Reset values: bgStart=0, sprStart=0, x=0, y=0, colour=0, plot=0, busy=0, frameDone=0. State=IDLE, pending=0, latched position=0.
- Reset mid-frame aborts immediately. Deasserted starts return the draw stages to IDLE.
- frameReq in cycle n: busy=1 and bgStart=1 in cycle n+1.
- Pixel path has 1-cycle latency. Input valid in cycle n gives plot/x/y/colour in cycle n+1. plot is 0 in any cycle with no accepted, unclipped pixel.
- bgDone seen in cycle n: bgStart=0 in cycle n+1.
- FINISH always lasts exactly one cycle.
- frameReq arriving in the same cycle as FINISH sets pending, and the sequencer restarts the next cycle.
- Minimum gap between frames is 0 idle cycles when pending.

## Structure
- Shared draw package holds:
  - SCREEN_W/SCREEN_H
  - TRANSPARENT
  - state encodings: 3-bit localparams IDLE, BG_RUN, BG_REL, SPR_RUN, SPR_REL, FINISH
  - coordinate widths
- One sub-module, pixel_merge: layer select, offset add, clip, key compare and output register. It takes the state as a layer-select input.
- The FSM, pending flag and position latch stay in draw_sequencer.

## Test plan
- Reset, then frameReq pulse, with stub stages asserting done after 5 writeEn each -> bgStart high 5+ cycles, drops, then sprStart. Ten plots, then frameDone pulse and busy=0.
- spriteX=150, spriteY=100, sprite pixel local (12,25) -> sx=162, sy=125, plot stays 0. Local (5,10) -> plot=1, x=155, y=110.
- Sprite pixel colour 8'hE3 at an on-screen location -> plot=0. Colour 8'hE2 -> plot=1, colour=8'hE2.
- frameReq asserted twice during BG_RUN -> exactly one extra frame. Second bgStart rises the cycle after frameDone. No third frame.
- sprWriteEn asserted during BG_RUN with bgWriteEn=0 -> plot stays 0.
- Reset asserted during SPR_RUN -> next cycle all outputs 0 and busy=0. Next frameReq starts with BG_RUN.
